cam_result_ctrl: RTL and testbench

CAM_RESULT_CTRL -- requirements
Module: cam_result_ctrl

---
 rtl/cam_pkg.sv | 19 +
 rtl/cam_result_fifo.sv | 51 +++++
 rtl/cam_result_ctrl.sv | 97 +++++++++
 tb/tb_cam_result_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types for the CAM result controller: default widths, result entry, FSM states.
package cam_pkg;

  localparam int unsigned CAM_DW_DEF = 32;
  localparam int unsigned CAM_AW_DEF = 8;

  typedef struct packed {
    logic                  hit;
    logic [CAM_AW_DEF-1:0] addr;
    logic [CAM_DW_DEF-1:0] data;
  } cam_result_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StAck  = 2'd2
  } cam_state_e;

endpackage

// File: rtl/cam_result_fifo.sv
// Synchronous result FIFO; empty slots read back as all-zero so outputs idle at reset values.
module cam_result_fifo
  import cam_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  cam_result_t            push_data,
  input  logic                   pop,
  output cam_result_t            pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  cam_result_t   mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_data;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign pop_data = empty ? '0 : mem_q[rptr_q];
  assign count    = count_q;

endmodule

// File: rtl/cam_result_ctrl.sv
// Turns CAM search windows into hit/miss results queued for a ready/valid consumer.
module cam_result_ctrl
  import cam_pkg::*;
#(
  parameter int unsigned CAM_DW     = CAM_DW_DEF,
  parameter int unsigned CAM_AW     = CAM_AW_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 21
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        search_start,
  input  logic                        cam_hit,
  input  logic [CAM_DW-1:0]           cam_data_out,
  input  logic [CAM_AW-1:0]           cam_addr_out,
  output logic                        cam_ack,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic                        res_hit,
  output logic [CAM_DW-1:0]           res_data,
  output logic [CAM_AW-1:0]           res_addr,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] res_count
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  cam_state_e    state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          push, pop, full, empty;
  cam_result_t   push_data, pop_data;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_data = '0;
    unique case (state_q)
      StIdle: begin
        if (search_start) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        // A full FIFO freezes the window; the hit checked first so it wins on the last cycle.
        if (!full) begin
          if (cam_hit) begin
            push      = 1'b1;
            push_data = '{hit: 1'b1, addr: cam_addr_out, data: cam_data_out};
            state_d   = StAck;
          end else if (cnt_q == TW'(TIMEOUT - 1)) begin
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  cam_result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .pop_data (pop_data),
    .full     (full),
    .empty    (empty),
    .count    (res_count)
  );

  assign res_valid = !empty;
  assign pop       = res_valid && res_ready;
  assign res_hit   = pop_data.hit;
  assign res_addr  = pop_data.addr;
  assign res_data  = pop_data.data;
  assign cam_ack   = (state_q == StAck);
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_cam_result_ctrl.sv
// Bench for cam_result_ctrl: queue-based reference model compared every cycle, plus directed checks.
module tb_cam_result_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int TO    = 21;

  logic          clk = 1'b0;
  logic          rst_n, search_start, cam_hit, res_ready;
  logic [DW-1:0] cam_data_out;
  logic [AW-1:0] cam_addr_out;
  logic          cam_ack, res_valid, res_hit, busy;
  logic [DW-1:0] res_data;
  logic [AW-1:0] res_addr;
  logic [2:0]    res_count;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  cam_result_ctrl #(
    .CAM_DW    (DW),
    .CAM_AW    (AW),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .search_start(search_start),
    .cam_hit     (cam_hit),
    .cam_data_out(cam_data_out),
    .cam_addr_out(cam_addr_out),
    .cam_ack     (cam_ack),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_hit     (res_hit),
    .res_data    (res_data),
    .res_addr    (res_addr),
    .busy        (busy),
    .res_count   (res_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a search window, an ack flag, and a queue of {hit, addr, data} results.
  logic [40:0] exp_q[$];
  logic [40:0] m_item, head;
  bit          m_search, m_ack, m_ack_n, m_have, m_full, m_pop;
  int          m_elapsed;

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_search  = 1'b0;
      m_elapsed = 0;
      m_ack     = 1'b0;
    end else begin
      m_full  = (exp_q.size() == DEPTH);
      m_pop   = (exp_q.size() != 0) && res_ready;
      m_have  = 1'b0;
      m_ack_n = 1'b0;
      if (m_search) begin
        if (!m_full) begin
          if (cam_hit) begin
            m_item   = {1'b1, cam_addr_out, cam_data_out};
            m_have   = 1'b1;
            m_search = 1'b0;
            m_ack_n  = 1'b1;
          end else if (m_elapsed == TO - 1) begin
            m_item   = '0;
            m_have   = 1'b1;
            m_search = 1'b0;
          end else begin
            m_elapsed++;
          end
        end
      end else if (!m_ack && search_start) begin
        m_search  = 1'b1;
        m_elapsed = 0;
      end
      if (m_pop) void'(exp_q.pop_front());
      if (m_have) exp_q.push_back(m_item);
      m_ack = m_ack_n;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      head = (exp_q.size() != 0) ? exp_q[0] : '0;
      chk("cam_ack", cam_ack, m_ack);
      chk("busy", busy, m_search || m_ack);
      chk("res_valid", res_valid, exp_q.size() != 0);
      chk("res_count", res_count, exp_q.size());
      chk("res_hit", res_hit, head[40]);
      chk("res_addr", res_addr, head[39:32]);
      chk("res_data", res_data, head[31:0]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Opens a window, waits 'waits' idle WAIT cycles, then presents a hit for one cycle.
  task automatic search_hit(input logic [AW-1:0] a, input logic [DW-1:0] d, input int waits);
    search_start = 1'b1;
    tick(1);
    search_start = 1'b0;
    tick(waits);
    cam_hit      = 1'b1;
    cam_addr_out = a;
    cam_data_out = d;
    tick(1);
    cam_hit = 1'b0;
  endtask

  logic [AW-1:0] got[$];

  initial begin
    rst_n = 1'b0; search_start = 1'b0; cam_hit = 1'b0; res_ready = 1'b0;
    cam_data_out = '0; cam_addr_out = '0;
    tick(1);
    cmp_en = 1'b1;
    tick(1);
    chk("rst_count", res_count, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(1);

    // Hit three cycles after start
    search_hit(8'h01, 32'hFFFF_FFFF, 2);
    chk("hit_ack", cam_ack, 1);
    chk("hit_valid", res_valid, 1);
    chk("hit_flag", res_hit, 1);
    chk("hit_addr", res_addr, 8'h01);
    chk("hit_data", res_data, 32'hFFFF_FFFF);
    tick(1);
    chk("hit_ack_drop", cam_ack, 0);
    chk("hit_idle", busy, 0);
    res_ready = 1'b1; tick(1); res_ready = 1'b0;
    chk("hit_popped", res_valid, 0);

    // Timeout with no hit
    search_start = 1'b1; tick(1); search_start = 1'b0;
    tick(TO - 1);
    chk("to_busy", busy, 1);
    chk("to_none_yet", res_valid, 0);
    tick(1);
    chk("to_valid", res_valid, 1);
    chk("to_miss", res_hit, 0);
    chk("to_busy_drop", busy, 0);
    res_ready = 1'b1; tick(1); res_ready = 1'b0;

    // Hit on the last WAIT cycle wins over timeout
    search_hit(8'h37, 32'h1234_5678, TO - 1);
    chk("last_hit", res_hit, 1);
    chk("last_ack", cam_ack, 1);
    chk("last_count", res_count, 1);
    tick(1);
    res_ready = 1'b1; tick(1); res_ready = 1'b0;

    // Fill FIFO, then a fifth hit stalls until a pop
    for (int i = 0; i < 4; i++) begin
      search_hit(8'(8'h10 + i), 32'(32'hA0 + i), 1);
      tick(1);
    end
    chk("full_count", res_count, 4);
    search_start = 1'b1; tick(1); search_start = 1'b0;
    cam_hit = 1'b1; cam_addr_out = 8'h14; cam_data_out = 32'hA4;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("stall_noack", cam_ack, 0);
      chk("stall_count", res_count, 4);
    end
    got.delete();
    res_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (res_valid) got.push_back(res_addr);
      if (cam_ack) cam_hit = 1'b0;
      tick(1);
    end
    res_ready = 1'b0;
    chk("order_n", got.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("order", (i < got.size()) ? got[i] : 8'hEE, 8'(8'h10 + i));

    // Reset mid-WAIT
    search_start = 1'b1; tick(1); search_start = 1'b0;
    tick(4);
    rst_n = 1'b0; tick(1);
    chk("abort_ack", cam_ack, 0);
    chk("abort_busy", busy, 0);
    chk("abort_count", res_count, 0);
    chk("abort_data", res_data, 0);
    rst_n = 1'b1; tick(2);
    chk("abort_noresult", res_valid, 0);

    // Simultaneous push and pop at occupancy 2
    search_hit(8'h20, 32'hB0, 0); tick(1);
    search_hit(8'h21, 32'hB1, 0); tick(1);
    chk("pp_pre", res_count, 2);
    search_start = 1'b1; tick(1); search_start = 1'b0;
    cam_hit = 1'b1; cam_addr_out = 8'h22; cam_data_out = 32'hB2; res_ready = 1'b1;
    tick(1);
    cam_hit = 1'b0; res_ready = 1'b0;
    chk("pp_count", res_count, 2);
    chk("pp_head", res_addr, 8'h21);
    chk("pp_ack", cam_ack, 1);
    tick(1);
    res_ready = 1'b1; tick(1);
    chk("pp_next", res_addr, 8'h22);
    tick(1); res_ready = 1'b0;
    chk("pp_drained", res_count, 0);
    tick(2);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
